// File: rtl/abuf2ddr_pkg.sv
// -----------------------------------------------------------------------------
// abuf2ddr_pkg
// Shared global parameters for the accumulation-buffer / DDR stream blocks:
// datapath widths, the bit-width helper bw(), the DDR transfer-type encoding
// and the tail-to-data beat ratio TD_RATE. Also holds the abuf2ddr FSM states.
// Optional feature macro used by abuf2ddr: ABUF2DDR_CLEAR_EN.
// -----------------------------------------------------------------------------
package abuf2ddr_pkg;

    localparam int DATA_W  = 8;              // accumulator data element width
    localparam int TAIL_W  = 16;             // accumulator tail element width
    localparam int BATCH   = 4;              // elements per abuf entry
    localparam int DDR_W   = BATCH * DATA_W; // DDR stream beat width
    localparam int TD_RATE = TAIL_W / DATA_W; // DDR beats per tail entry

    typedef enum logic [1:0] {
        TRANS_DATA      = 2'b00,
        TRANS_ABUF_TAIL = 2'b01,
        TRANS_BIAS_DATA = 2'b10,
        TRANS_BIAS_TAIL = 2'b11
    } trans_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } a2d_state_t;

    // Bits needed to index n items; never less than 1.
    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/abuf2ddr_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with combinational (first-word fall-through) read data.
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data    push; ignored while full
//   rd_en, rd_data    pop; rd_data always shows the head entry
//   count, full, empty  occupancy status
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/abuf2ddr.sv
// -----------------------------------------------------------------------------
// abuf2ddr
// Write-back path from one PE's accumulation buffer to the DDR write stream.
// A configuration request selects a PE, a transfer type (data or tail) and a
// beat count; the block reads abuf entries, buffers them in a small skid FIFO
// and emits them as DDR_W-wide beats, tail entries split into TD_RATE beats.
// Optional feature macro: ABUF2DDR_CLEAR_EN -- when defined, every read entry
// is written back to zero in the cycle its data returns.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   conf_valid/conf_ready         transfer request handshake
//   conf_trans_type/num/pe_sel    transfer type, DDR beat count, source PE
//   abuf_rd_addr, abuf_rd_en      abuf read request (address broadcast, one-hot)
//   abuf_rd_data, abuf_rd_tail    per-PE read data, 1-cycle latency
//   abuf_clr_addr, abuf_clr_en    abuf clear-write request
//   ddr_data/valid/last/ready     DDR write stream
// -----------------------------------------------------------------------------
module abuf2ddr
    import abuf2ddr_pkg::*;
#(
    parameter int BUF_DEPTH  = 256,
    parameter int PE_NUM     = 32,
    parameter int ADDR_W     = bw(BUF_DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             conf_valid,
    output logic                             conf_ready,
    input  logic [1:0]                       conf_trans_type,
    input  logic [15:0]                      conf_trans_num,
    input  logic [bw(PE_NUM)-1:0]            conf_pe_sel,
    output logic [ADDR_W-1:0]                abuf_rd_addr,
    output logic [PE_NUM-1:0]                abuf_rd_en,
    input  logic [PE_NUM*BATCH*DATA_W-1:0]   abuf_rd_data,
    input  logic [PE_NUM*BATCH*TAIL_W-1:0]   abuf_rd_tail,
    output logic [ADDR_W-1:0]                abuf_clr_addr,
    output logic [PE_NUM-1:0]                abuf_clr_en,
    output logic [DDR_W-1:0]                 ddr_data,
    output logic                             ddr_valid,
    output logic                             ddr_last,
    input  logic                             ddr_ready
);

    localparam int PE_W  = bw(PE_NUM);
    localparam int ENT_W = BATCH * TAIL_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SLC_W = bw(TD_RATE);

    a2d_state_t        state;
    a2d_state_t        state_nxt;
    logic              tail_q;
    logic [15:0]       num_q;
    logic [PE_W-1:0]   pe_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [15:0]       issued_q;
    logic [15:0]       sent_q;
    logic [SLC_W-1:0]  slc_q;
    logic              vld_p1;

    logic              accept;
    logic              start;
    logic              issue;
    logic              hs;
    logic              last_beat;
    logic              slice_last;
    logic              pop;
    logic [16:0]       issued_sum;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  push_data;
    logic [ENT_W-1:0]  head;

    assign conf_ready = (state == IDLE);
    assign accept     = conf_valid && conf_ready;
    // Empty requests and bias types are accepted but never leave IDLE.
    assign start      = accept && (conf_trans_num != 16'd0) &&
                        ((conf_trans_type == TRANS_DATA) ||
                         (conf_trans_type == TRANS_ABUF_TAIL));

    // Credit check counts reads still in flight so a returning entry always
    // finds a free FIFO slot.
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p1};
    assign issue      = (state == RUN) && (issued_q < num_q) && !fifo_full &&
                        (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign issued_sum = {1'b0, issued_q} + (tail_q ? 17'(TD_RATE) : 17'd1);

    assign abuf_rd_addr = rd_addr_q;
    assign abuf_rd_en   = issue ? (PE_NUM'(1) << pe_q) : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN: begin
                if (hs && last_beat)        state_nxt = IDLE;
                else if (issued_q >= num_q) state_nxt = DRAIN;
            end
            DRAIN:   if (hs && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tail_q    <= 1'b0;
            num_q     <= '0;
            pe_q      <= '0;
            rd_addr_q <= '0;
            issued_q  <= '0;
            sent_q    <= '0;
            slc_q     <= '0;
            vld_p1    <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= issue;
            if (accept) begin
                tail_q    <= (conf_trans_type == TRANS_ABUF_TAIL);
                num_q     <= conf_trans_num;
                pe_q      <= conf_pe_sel;
                rd_addr_q <= '0;
                issued_q  <= '0;
                sent_q    <= '0;
                slc_q     <= '0;
            end else begin
                if (issue) begin
                    rd_addr_q <= (rd_addr_q == ADDR_W'(BUF_DEPTH - 1)) ?
                                 '0 : rd_addr_q + ADDR_W'(1);
                    // Saturate so a tail overshoot near 16'hFFFF cannot wrap.
                    issued_q  <= issued_sum[16] ? 16'hFFFF : issued_sum[15:0];
                end
                if (hs) begin
                    sent_q <= sent_q + 16'd1;
                    slc_q  <= slice_last ? '0 : slc_q + SLC_W'(1);
                end
            end
        end
    end

    // ---- p1: read data returns from the selected PE and is pushed ----
    always_comb begin
        push_data = '0;
        if (tail_q) begin
            push_data = abuf_rd_tail[pe_q*ENT_W +: ENT_W];
        end else begin
            push_data[DDR_W-1:0] = abuf_rd_data[pe_q*DDR_W +: DDR_W];
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_p1),
        .wr_data (push_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef ABUF2DDR_CLEAR_EN
    logic [ADDR_W-1:0] addr_p1;

    always_ff @(posedge clk) begin
        if (issue) begin
            addr_p1 <= rd_addr_q;
        end
    end

    assign abuf_clr_en   = vld_p1 ? (PE_NUM'(1) << pe_q) : '0;
    assign abuf_clr_addr = vld_p1 ? addr_p1 : '0;
`else
    assign abuf_clr_en   = '0;
    assign abuf_clr_addr = '0;
`endif

    // ---- p2: FIFO head sliced onto the DDR stream ----
    // A tail entry is retired after its TD_RATE-th slice, or earlier when the
    // transfer ends mid-entry.
    assign ddr_valid  = !fifo_empty;
    assign last_beat  = ((sent_q + 16'd1) == num_q);
    assign hs         = ddr_valid && ddr_ready;
    assign slice_last = !tail_q || (slc_q == SLC_W'(TD_RATE - 1)) || last_beat;
    assign pop        = hs && slice_last;
    assign ddr_last   = ddr_valid && last_beat;
    assign ddr_data   = fifo_empty ? '0 : head[slc_q*DDR_W +: DDR_W];

endmodule

// File: tb/tb_abuf2ddr.sv
// -----------------------------------------------------------------------------
// tb_abuf2ddr
// Directed bench for abuf2ddr: data and tail transfers, backpressure, empty and
// rejected requests, mid-transfer reset and the optional clear-write port.
// A behavioural abuf model returns a PE/address-dependent pattern one cycle
// after each read; non-selected cycles return junk.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_abuf2ddr;

    localparam int PE_NUM = 32;
    localparam int DW     = 32;   // BATCH*DATA_W
    localparam int TW     = 64;   // BATCH*TAIL_W

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 conf_valid;
    logic                 conf_ready;
    logic [1:0]           conf_trans_type;
    logic [15:0]          conf_trans_num;
    logic [4:0]           conf_pe_sel;
    logic [7:0]           abuf_rd_addr;
    logic [PE_NUM-1:0]    abuf_rd_en;
    logic [PE_NUM*DW-1:0] abuf_rd_data;
    logic [PE_NUM*TW-1:0] abuf_rd_tail;
    logic [7:0]           abuf_clr_addr;
    logic [PE_NUM-1:0]    abuf_clr_en;
    logic [DW-1:0]        ddr_data;
    logic                 ddr_valid;
    logic                 ddr_last;
    logic                 ddr_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    abuf2ddr dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .conf_valid      (conf_valid),
        .conf_ready      (conf_ready),
        .conf_trans_type (conf_trans_type),
        .conf_trans_num  (conf_trans_num),
        .conf_pe_sel     (conf_pe_sel),
        .abuf_rd_addr    (abuf_rd_addr),
        .abuf_rd_en      (abuf_rd_en),
        .abuf_rd_data    (abuf_rd_data),
        .abuf_rd_tail    (abuf_rd_tail),
        .abuf_clr_addr   (abuf_clr_addr),
        .abuf_clr_en     (abuf_clr_en),
        .ddr_data        (ddr_data),
        .ddr_valid       (ddr_valid),
        .ddr_last        (ddr_last),
        .ddr_ready       (ddr_ready)
    );

    function automatic logic [31:0] dval(input int pe, input int addr);
        return {8'(pe), 8'(addr), 8'h5A ^ 8'(addr * 3), 8'(pe * 7 + addr)};
    endfunction

    function automatic logic [63:0] tval(input int pe, input int addr);
        return {8'hC3 ^ 8'(addr), 8'(pe + 100), 8'(addr), 8'h11,
                dval(pe, addr) ^ 32'h0F0F_1234};
    endfunction

    // abuf model: 1-cycle read latency, junk whenever a PE is not read.
    always @(posedge clk) begin
        for (int p = 0; p < PE_NUM; p++) begin
            if (abuf_rd_en[p]) begin
                abuf_rd_data[p*DW +: DW] <= dval(p, int'(abuf_rd_addr));
                abuf_rd_tail[p*TW +: TW] <= tval(p, int'(abuf_rd_addr));
            end else begin
                abuf_rd_data[p*DW +: DW] <= 32'hDEAD_0000 | 32'(p);
                abuf_rd_tail[p*TW +: TW] <= 64'hBAD0_BAD0_0000_0000 | 64'(p);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer. mode 0: ddr_ready held high; mode 1: ready toggles
    // and is held low for cycles 4..13. Cycle 0 is the acceptance cycle.
    task automatic run_xfer(input logic [1:0] ttype, input int num, input int pe,
                            input int mode, output int first_rd, output int first_vld,
                            output int last_cyc, output int rdy_cyc);
        int reads = 0;
        int beats = 0;
        logic stalled = 1'b0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        logic [PE_NUM-1:0] prev_en = '0;
        logic [7:0] prev_addr = '0;
        logic [63:0] exp;
        first_rd = -1; first_vld = -1; last_cyc = -1; rdy_cyc = -1;
        @(negedge clk);
        check("conf_ready_idle", 64'(conf_ready), 64'd1);
        conf_valid      = 1'b1;
        conf_trans_type = ttype;
        conf_trans_num  = 16'(num);
        conf_pe_sel     = 5'(pe);
        ddr_ready       = 1'b1;
        @(negedge clk);
        conf_valid = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            ddr_ready = (mode == 0) ? 1'b1 : ((k >= 4 && k < 14) ? 1'b0 : (k % 2 == 1));
            if (abuf_rd_en != '0) begin
                if (first_rd < 0) first_rd = k;
                check("rd_en_onehot", 64'(abuf_rd_en), 64'(32'd1 << pe));
                check("rd_addr", 64'(abuf_rd_addr), 64'(reads % 256));
                reads++;
            end
`ifdef ABUF2DDR_CLEAR_EN
            check("clr_en", 64'(abuf_clr_en), 64'(prev_en));
            if (prev_en != '0) check("clr_addr", 64'(abuf_clr_addr), 64'(prev_addr));
`else
            check("clr_en_off", 64'(abuf_clr_en), 64'd0);
`endif
            if (stalled) begin
                check("stall_valid", 64'(ddr_valid), 64'd1);
                check("stall_data", 64'(ddr_data), 64'(pd));
                check("stall_last", 64'(ddr_last), 64'(pl));
            end
            if (ddr_valid) begin
                if (first_vld < 0) first_vld = k;
                if (ddr_ready) begin
                    if (ttype == 2'b01) begin
                        exp = tval(pe, beats / 2);
                        exp = (beats % 2 == 0) ? {32'd0, exp[31:0]} : {32'd0, exp[63:32]};
                    end else begin
                        exp = 64'(dval(pe, beats));
                    end
                    check("beat_data", 64'(ddr_data), exp);
                    check("beat_last", 64'(ddr_last), 64'(beats == num - 1));
                    if (ddr_last) last_cyc = k;
                    beats++;
                end
            end
            if (ttype == 2'b00) check("outstanding_le_4", 64'((reads - beats) <= 4), 64'd1);
            stalled   = ddr_valid && !ddr_ready;
            pd        = ddr_data;
            pl        = ddr_last;
            prev_en   = abuf_rd_en;
            prev_addr = abuf_rd_addr;
            if (beats == num && conf_ready) begin
                rdy_cyc = k;
                break;
            end
            @(negedge clk);
        end
        ddr_ready = 1'b1;
        check("xfer_done_in_budget", 64'(rdy_cyc > 0), 64'd1);
        check("beat_count", 64'(beats), 64'(num));
        check("read_count", 64'(reads), 64'((ttype == 2'b01) ? (num + 1) / 2 : num));
    endtask

    // Request that must be swallowed in IDLE: no reads, no beats.
    task automatic run_reject(input logic [1:0] ttype, input int num);
        @(negedge clk);
        conf_valid      = 1'b1;
        conf_trans_type = ttype;
        conf_trans_num  = 16'(num);
        conf_pe_sel     = 5'd4;
        @(negedge clk);
        conf_valid = 1'b0;
        check("reject_conf_ready", 64'(conf_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("reject_no_rd", 64'(abuf_rd_en), 64'd0);
            check("reject_no_valid", 64'(ddr_valid), 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int fr, fv, lc, rc;
        rst_n           = 1'b0;
        conf_valid      = 1'b0;
        conf_trans_type = 2'b00;
        conf_trans_num  = 16'd0;
        conf_pe_sel     = 5'd0;
        ddr_ready       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_conf_ready", 64'(conf_ready), 64'd1);
        check("rst_rd_en", 64'(abuf_rd_en), 64'd0);
        check("rst_clr_en", 64'(abuf_clr_en), 64'd0);
        check("rst_rd_addr", 64'(abuf_rd_addr), 64'd0);
        check("rst_clr_addr", 64'(abuf_clr_addr), 64'd0);
        check("rst_ddr_valid", 64'(ddr_valid), 64'd0);
        check("rst_ddr_last", 64'(ddr_last), 64'd0);
        check("rst_ddr_data", 64'(ddr_data), 64'd0);
        rst_n = 1'b1;

        // Data, PE 5, 8 beats, full rate.
        run_xfer(2'b00, 8, 5, 0, fr, fv, lc, rc);
        check("data_first_rd_cycle", 64'(fr), 64'd1);
        check("data_first_valid_cycle", 64'(fv), 64'd3);
        check("data_last_cycle", 64'(lc), 64'd10);
        check("data_conf_ready_cycle", 64'(rc), 64'd11);

        // Tail, PE 2, 5 beats: 3 reads, last entry low half only.
        run_xfer(2'b01, 5, 2, 0, fr, fv, lc, rc);
        check("tail_first_valid_cycle", 64'(fv), 64'd3);

        // Backpressure, data and tail.
        run_xfer(2'b00, 12, 7, 1, fr, fv, lc, rc);
        run_xfer(2'b01, 9, 30, 1, fr, fv, lc, rc);

        // Requests that must not start a transfer.
        run_reject(2'b00, 0);
        run_reject(2'b10, 4);
        run_reject(2'b11, 6);

        // Reset while the third of eight beats is on the bus.
        @(negedge clk);
        conf_valid      = 1'b1;
        conf_trans_type = 2'b00;
        conf_trans_num  = 16'd8;
        conf_pe_sel     = 5'd1;
        @(negedge clk);
        conf_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_valid", 64'(ddr_valid), 64'd1);
        check("pre_rst_data", 64'(ddr_data), 64'(dval(1, 2)));
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(ddr_valid), 64'd0);
        check("midrst_last", 64'(ddr_last), 64'd0);
        check("midrst_conf_ready", 64'(conf_ready), 64'd1);
        check("midrst_rd_en", 64'(abuf_rd_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(2'b00, 4, 3, 0, fr, fv, lc, rc);
        check("post_rst_first_valid_cycle", 64'(fv), 64'd3);

        // Short data transfer exercising the clear-write port.
        run_xfer(2'b00, 4, 9, 0, fr, fv, lc, rc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
